// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch stage: program counter, imem req/ack, instruction FIFO, redirect
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic            target_sel,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] immext,
  input  logic [XLEN-1:0] alu_result,
  output logic            misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            misalign_q, misalign_d;

  logic [31:0]     fifo_instr_mem [DEPTH];
  logic [XLEN-1:0] fifo_pc_mem    [DEPTH];

  logic [XLEN-1:0] target;
  logic            pop;
  logic            push;
  logic            space;
  logic [CW-1:0]   pop_ext;
  logic [CW-1:0]   push_ext;

  // Redirect target and FIFO occupancy terms; a redirect suppresses the pop.
  always_comb begin
    target   = target_sel ? (alu_result & ~XLEN'(1)) : (redirect_pc + immext);
    pop      = (count_q != '0) && instr_ready && !redirect;
    pop_ext  = {{(CW-1){1'b0}}, pop};
    push_ext = {{(CW-1){1'b0}}, push};
    space    = (count_q - pop_ext) < DEPTH_C;
  end

  // Fetch FSM: one outstanding request; DRAIN swallows the response of a request made stale by a redirect.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    push       = 1'b0;
    misalign_d = redirect && (target[1:0] != 2'b00);
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = REQ;
        end else if (space) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = target;
          if (imem_ack) begin
            state_d = REQ;
          end else begin
            pend_pc_d = fetch_pc_q;
            state_d   = DRAIN;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          state_d    = ((count_q - pop_ext + ONE_C) < DEPTH_C) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (redirect) begin
          fetch_pc_d = target;
        end
        state_d = imem_ack ? REQ : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer/count update; a redirect flushes everything on the same edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + push_ext - pop_ext;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // FIFO storage; contents are only visible through the count-gated outputs, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_mem[wr_ptr_q] <= imem_rdata;
      fifo_pc_mem[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  // Outputs: head entry is zeroed while the FIFO is empty.
  always_comb begin
    imem_req    = (state_q == REQ) || (state_q == DRAIN);
    imem_addr   = (state_q == DRAIN) ? pend_pc_q : fetch_pc_q;
    instr_valid = (count_q != '0);
    instr       = instr_valid ? fifo_instr_mem[rd_ptr_q] : '0;
    instr_pc    = instr_valid ? fifo_pc_mem[rd_ptr_q] : '0;
    misalign    = misalign_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic        target_sel;
  logic [31:0] redirect_pc;
  logic [31:0] immext;
  logic [31:0] alu_result;
  logic        misalign;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .target_sel(target_sel), .redirect_pc(redirect_pc),
    .immext(immext), .alu_result(alu_result), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: queue of fetched {instr, pc}, plus the one bus request that may be outstanding.
  logic [31:0] mq_instr[$];
  logic [31:0] mq_pc[$];
  logic        m_out;
  logic        m_stale;
  logic        m_mis;
  logic [31:0] m_addr_out;
  logic [31:0] m_next;
  int          m_wait;
  int          lat;

  function automatic logic [31:0] instr_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    mq_instr.delete();
    mq_pc.delete();
    m_out      = 1'b0;
    m_stale    = 1'b0;
    m_mis      = 1'b0;
    m_addr_out = 32'h0;
    m_next     = 32'h0;
    m_wait     = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit do_pop;
    bit acked;
    bit issued;
    if (rst) begin
      model_reset();
      return;
    end
    issued = 1'b0;
    do_pop = (mq_pc.size() > 0) && instr_ready && !redirect;
    acked  = m_out && imem_ack;
    if (redirect) begin
      tgt    = target_sel ? (alu_result & 32'hFFFF_FFFE) : (redirect_pc + immext);
      m_mis  = (tgt[1:0] != 2'b00);
      mq_instr.delete();
      mq_pc.delete();
      m_next = tgt;
      if (m_out && !acked) begin
        m_stale = 1'b1;
      end else begin
        m_out      = 1'b1;
        m_stale    = 1'b0;
        m_addr_out = tgt;
        issued     = 1'b1;
      end
    end else begin
      m_mis = 1'b0;
      if (do_pop) begin
        void'(mq_instr.pop_front());
        void'(mq_pc.pop_front());
      end
      if (acked) begin
        if (!m_stale) begin
          mq_instr.push_back(instr_word(m_addr_out));
          mq_pc.push_back(m_addr_out);
          m_next = m_addr_out + 32'd4;
        end
        m_out   = 1'b0;
        m_stale = 1'b0;
      end
      if (!m_out && mq_pc.size() < DEPTH) begin
        m_out      = 1'b1;
        m_addr_out = m_next;
        issued     = 1'b1;
      end
    end
    if (issued) m_wait = 0;
    else if (m_out) m_wait++;
  endtask

  task automatic drive_mem();
    imem_ack   = m_out && (m_wait >= lat);
    imem_rdata = m_out ? instr_word(m_addr_out) : 32'h0;
  endtask

  task automatic set_lat(input int n);
    lat = n;
    drive_mem();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    drive_mem();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    redirect    = 1'b0;
    target_sel  = 1'b0;
    redirect_pc = 32'h0;
    immext      = 32'h0;
    alu_result  = 32'h0;
    instr_ready = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    tick();
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " imem_req"}, 32'(imem_req), 32'h0);
    chk({tag, " imem_addr"}, imem_addr, 32'h0);
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, " instr"}, instr, 32'h0);
    chk({tag, " instr_pc"}, instr_pc, 32'h0);
    chk({tag, " misalign"}, 32'(misalign), 32'h0);
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("cyc imem_req", 32'(imem_req), 32'(m_out));
    chk("cyc imem_addr", imem_addr, m_out ? m_addr_out : m_next);
    chk("cyc instr_valid", 32'(instr_valid), 32'(mq_pc.size() > 0));
    chk("cyc instr", instr, (mq_pc.size() > 0) ? mq_instr[0] : 32'h0);
    chk("cyc instr_pc", instr_pc, (mq_pc.size() > 0) ? mq_pc[0] : 32'h0);
    chk("cyc misalign", 32'(misalign), 32'(m_mis));
  end

  initial begin
    lat = 0;
    // Reset values, then zero-wait streaming with a spurious ack before the first request.
    do_reset();
    chk_reset_vals("rst");
    rst = 1'b0;
    instr_ready = 1'b1;
    set_lat(0);
    imem_ack = 1'b1;
    tick();
    chk("t1 req", 32'(imem_req), 32'h1);
    chk("t1 addr0", imem_addr, 32'h0);
    tick();
    chk("t1 addr4", imem_addr, 32'h4);
    chk("t1 pc0", instr_pc, 32'h0);
    chk("t1 instr0", instr, 32'hC0DE_0013);
    tick();
    chk("t1 addr8", imem_addr, 32'h8);
    chk("t1 pc4", instr_pc, 32'h4);

    // Backpressure: two entries buffered, request drops, resumes at 0x8.
    do_reset();
    rst = 1'b0;
    set_lat(0);
    tick();
    tick();
    tick();
    chk("t2 req low", 32'(imem_req), 32'h0);
    chk("t2 valid", 32'(instr_valid), 32'h1);
    chk("t2 head pc", instr_pc, 32'h0);
    tick();
    chk("t2 still idle", 32'(imem_req), 32'h0);
    instr_ready = 1'b1;
    tick();
    chk("t2 resume req", 32'(imem_req), 32'h1);
    chk("t2 resume addr", imem_addr, 32'h8);
    chk("t2 head pc4", instr_pc, 32'h4);

    // Branch redirect with negative immediate while an ack lands in the same cycle.
    do_reset();
    rst = 1'b0;
    set_lat(0);
    tick();
    tick();
    redirect = 1'b1; target_sel = 1'b0; redirect_pc = 32'h10; immext = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    chk("t3 flushed", 32'(instr_valid), 32'h0);
    chk("t3 addr", imem_addr, 32'h8);
    tick();
    chk("t3 head pc", instr_pc, 32'h8);

    // Slow memory: redirect during wait, old address held until the stale ack.
    do_reset();
    rst = 1'b0;
    instr_ready = 1'b1;
    set_lat(3);
    tick();
    tick();
    redirect = 1'b1; target_sel = 1'b0; redirect_pc = 32'h40; immext = 32'h0;
    tick();
    redirect = 1'b0;
    chk("t4 drain req", 32'(imem_req), 32'h1);
    chk("t4 drain addr", imem_addr, 32'h0);
    tick();
    chk("t4 drain addr2", imem_addr, 32'h0);
    tick();
    chk("t4 new addr", imem_addr, 32'h40);
    chk("t4 dropped", 32'(instr_valid), 32'h0);
    set_lat(0);
    tick();
    chk("t4 head pc", instr_pc, 32'h40);

    // JALR to odd address: bit0 cleared, misaligned target flagged; wrapping branch add.
    do_reset();
    rst = 1'b0;
    instr_ready = 1'b1;
    set_lat(0);
    tick();
    redirect = 1'b1; target_sel = 1'b1; alu_result = 32'h103;
    tick();
    redirect = 1'b0;
    chk("t5 jalr addr", imem_addr, 32'h102);
    chk("t5 misalign", 32'(misalign), 32'h1);
    tick();
    chk("t5 misalign clr", 32'(misalign), 32'h0);
    chk("t5 head pc", instr_pc, 32'h102);
    redirect = 1'b1; target_sel = 1'b0; redirect_pc = 32'hFFFF_FFFC; immext = 32'h8;
    tick();
    redirect = 1'b0;
    chk("t5 wrap addr", imem_addr, 32'h4);
    chk("t5 wrap aligned", 32'(misalign), 32'h0);

    // Reset in the middle of an outstanding request.
    do_reset();
    rst = 1'b0;
    set_lat(0);
    tick();
    tick();
    set_lat(5);
    tick();
    chk("t6 pending req", 32'(imem_req), 32'h1);
    chk("t6 pending addr", imem_addr, 32'h4);
    rst = 1'b1;
    model_reset();
    #1;
    chk_reset_vals("t6 async");
    tick();
    rst = 1'b0;
    set_lat(0);
    tick();
    chk("t6 first req", 32'(imem_req), 32'h1);
    chk("t6 first addr", imem_addr, 32'h0);

    // Mixed latency, backpressure and periodic redirects, checked by the per-cycle compare.
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      instr_ready = (i % 5) != 2;
      if (i % 40 == 0) set_lat((i / 40) % 3);
      redirect    = (i % 37) == 36;
      target_sel  = (i % 74) == 36;
      alu_result  = 32'h1000 + 32'(i);
      redirect_pc = 32'h2000 + 32'(4 * i);
      immext      = (i % 3 == 0) ? 32'hFFFF_FF00 : 32'h20;
      tick();
      redirect = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
